uart_rx_framer: RTL
===================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have port clk  input  1  16x-oversample clock (16 clk cycles per bit period); all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port rx_in  input  1  asynchronous serial line; idle high; LSB-first 8N1 frames.
REQ-004 SHALL have port bsc_count  input  4  bit-sample count from the sample counter; 0..15, wraps 15->0 while enabled.
REQ-005 SHALL have port bsc_en  output  1  sample-counter enable; counter is held at 0 while low.
REQ-006 SHALL have port data_out  output  8  last correctly framed byte.
REQ-007 SHALL have port data_valid  output  1  one-cycle strobe: data_out updated this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle strobe: stop bit sampled low.

Function
REQ-009 SHALL pass rx_in through a 2-flop synchronizer; "rx" below means the synchronizer output.
REQ-010 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-022).
REQ-011 SHALL drive bsc_en = 1 in every state except IDLE, decoded from the state register only.
REQ-012 IDLE: rx==0 in a cycle -> START next cycle; otherwise stay.
REQ-013 START: at bsc_count==7, rx==1 -> false start, go IDLE with no strobe; rx==0 -> stay; at bsc_count==15 -> DATA with bit index 0.
REQ-014 DATA: at bsc_count==7, shift rx into bit 7 of an 8-bit shift register, shifting right, so the first bit lands in bit 0.
REQ-015 DATA: at bsc_count==15, increment the 3-bit bit index; at index 7 -> STOP (or PARITY) instead.
REQ-016 STOP: at bsc_count==7 go IDLE the next cycle, which deasserts bsc_en so the next start edge is caught early.
REQ-017 STOP with rx==1: data_out <= shift register and data_valid = 1 for exactly that cycle.
REQ-018 STOP with rx==0: frame_err = 1 for one cycle; data_out holds its previous value; data_valid stays 0.
REQ-019 data_valid and frame_err SHALL never be high in the same cycle, and each SHALL be 0 in all other cycles.
REQ-020 rx edges outside bsc_count==7 SHALL have no effect in START, DATA or STOP.

Reset
REQ-021 rst==1 at a clock edge SHALL set, at any state including mid-frame:
- state=IDLE, bsc_en=0, data_out=8'h00, data_valid=0, frame_err=0
- shift register=0, bit index=0, synchronizer flops=1
- the partial frame is discarded with no strobe.

Configuration
REQ-022 With macro UART_RX_PARITY_EN defined: SHALL add state PARITY (entered from DATA after bit 7; leaves to STOP at bsc_count==15) and output parity_err (1 bit, reset 0).
REQ-023 parity_err SHALL pulse at the STOP sample when the rx sampled at PARITY bsc_count==7 does not equal XOR of the 8 data bits (even parity).
REQ-024 parity_err is independent of frame_err.
REQ-025 A parity error SHALL still update data_out and pulse data_valid if the stop bit is 1.
REQ-026 Without UART_RX_PARITY_EN: no PARITY state and no parity_err port; frame is 8N1.

Verification
REQ-027 After reset, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 clk/bit -> data_valid one cycle at stop mid-bit, data_out=8'hA5, frame_err=0, bsc_en then 0.
REQ-028 rx low 3 cycles then high -> START aborts at bsc_count==7, returns IDLE, no strobes, data_out unchanged.
REQ-029 Frame 0x3C with stop bit 0 after a good 0xA5 -> frame_err one cycle, data_valid 0, data_out stays 8'hA5.
REQ-030 rst pulsed during data bit 4 -> next cycle state IDLE, bsc_en=0, all outputs zero; a following 0x81 frame is received correctly.
REQ-031 Back-to-back 0x00 then 0xFF, start bit immediately after stop -> two data_valid strobes with 8'h00 then 8'hFF.
REQ-032 UART_RX_PARITY_EN defined, 0x07 sent with parity bit 0 -> data_valid, data_out=8'h07, parity_err one cycle; with parity bit 1 -> parity_err 0.

Source files
------------

// File: rtl/uart_rx_framer.sv
// UART 8N1 receive framer driven by a 16x oversample clock and an external bit-sample counter.
// Latency: strobes appear the cycle after the stop bit's mid-sample (bsc_count==7).
// Backpressure: none; data_out/data_valid is a fire-and-forget strobe.
// Optional even-parity support (9-bit frames, parity_err output) when UART_RX_PARITY_EN is defined.
module uart_rx_framer (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [3:0] bsc_count,
    output logic       bsc_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
`ifdef UART_RX_PARITY_EN
    logic       parity_bit;
`endif

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx      <= rx_meta;
        end
    end

    // The sample counter runs whenever a frame is in progress.
    assign bsc_en = (state != S_IDLE);

    // Frame state machine: mid-bit sampling at count 7, bit advance at count 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shift_reg  <= 8'h00;
            bit_idx    <= 3'd0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!rx) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    // A line that is high again at mid-start-bit was a glitch.
                    if (bsc_count == 4'd7 && rx) begin
                        state <= S_IDLE;
                    end else if (bsc_count == 4'd15) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (bsc_count == 4'd7) begin
                        shift_reg <= {rx, shift_reg[7:1]};
                    end else if (bsc_count == 4'd15) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bsc_count == 4'd7) begin
                        parity_bit <= rx;
                    end else if (bsc_count == 4'd15) begin
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Leave at mid-stop so the counter is cleared before the next start edge.
                    if (bsc_count == 4'd7) begin
                        state <= S_IDLE;
                        if (rx) begin
                            data_out   <= shift_reg;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err <= (parity_bit != ^shift_reg);
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
